// File: rtl/manual_step_gen_pkg.sv
// Shared processor constants: manual-step FSM state encoding, clock-select codes
// and small elaboration-time helpers.
package manual_step_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HIGH    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } step_state_e;

    localparam logic [1:0] CLKSEL_AUTO   = 2'd0;
    localparam logic [1:0] CLKSEL_MANUAL = 2'd1;
    localparam logic [1:0] CLKSEL_SLOW   = 2'd2;
    localparam logic [1:0] CLKSEL_HALT   = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reset value is a parameter
// so active-low switches can reset to their released level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/manual_step_gen.sv
// Debounced single-step clock generator: one fixed-width pulse on manual per
// accepted button press, with a wrapping step counter for the display.
module manual_step_gen
    import manual_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 2500000
) (
    input  logic       in_clock,
    input  logic       reset_n,
    input  logic       button,
    input  logic       ena,
    output logic       manual,
    output logic [7:0] step_count,
    output logic       busy
);

    localparam int unsigned CW = $clog2(max_u(DEBOUNCE_CYCLES, PULSE_CYCLES));
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

    step_state_e   state;
    logic [CW-1:0] cnt;
    logic          button_q;
    logic          btn_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (in_clock),
        .rst_n (reset_n),
        .d     (button),
        .q     (button_q)
    );

    assign btn_s = ~button_q;

    // manual and busy are registered alongside state so each always equals a
    // decode of the current state without any combinational path to button.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            manual     <= 1'b0;
            busy       <= 1'b0;
            step_count <= '0;
        end else if (!ena) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            manual <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_s) begin
                        state <= ST_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        state      <= ST_HIGH;
                        cnt        <= '0;
                        manual     <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == PULSE_LAST) begin
                        state  <= ST_HOLD;
                        manual <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!btn_s) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (btn_s) begin
                        state <= ST_HOLD;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    manual <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manual_step_gen.sv
// Directed bench for manual_step_gen with short debounce/pulse lengths.
module tb_manual_step_gen;

    localparam int unsigned DEB = 4;
    localparam int unsigned PUL = 3;

    logic       in_clock = 1'b0;
    logic       reset_n;
    logic       button;
    logic       ena;
    logic       manual;
    logic       busy;
    logic [7:0] step_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulses   = 0;
    logic        prev_manual = 1'b0;

    manual_step_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_CYCLES    (PUL)
    ) dut (
        .in_clock   (in_clock),
        .reset_n    (reset_n),
        .button     (button),
        .ena        (ena),
        .manual     (manual),
        .step_count (step_count),
        .busy       (busy)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: rising edge, then settle at the falling edge where outputs are sampled.
    task automatic cyc();
        @(posedge in_clock);
        @(negedge in_clock);
        if (manual && !prev_manual) pulses++;
        prev_manual = manual;
    endtask

    task automatic press_release(input int hold, input int rel);
        button = 1'b0;
        repeat (hold) cyc();
        button = 1'b1;
        repeat (rel) cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        button  = 1'b1;
        ena     = 1'b1;
        repeat (2) cyc();
        check("rst_manual", 32'(manual), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_steps",  32'(step_count), 32'd0);
        reset_n = 1'b1;
        repeat (3) cyc();

        // Clean press: pulse on edges 7..9, busy from edge 3 (PRESS entered)
        button = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check($sformatf("clean_manual_e%0d", k), 32'(manual), 32'((k >= 7 && k <= 9) ? 1 : 0));
            check($sformatf("clean_busy_e%0d", k), 32'(busy), 32'((k >= 3) ? 1 : 0));
        end
        check("clean_steps", 32'(step_count), 32'd1);
        button = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("release_busy_e%0d", k), 32'(busy), 32'((k < 7) ? 1 : 0));
        end

        // Bounced press never reaches HIGH
        pulses = 0;
        button = 1'b0; repeat (2) cyc();
        button = 1'b1; cyc();
        button = 1'b0; repeat (2) cyc();
        button = 1'b1; repeat (12) cyc();
        check("bounce_pulses", pulses, 32'd0);
        check("bounce_steps", 32'(step_count), 32'd1);
        check("bounce_busy", 32'(busy), 32'd0);

        // Long hold with bouncy release, then a second clean press
        do_reset();
        pulses = 0;
        button = 1'b0;
        repeat (1000) cyc();
        check("hold_pulses", pulses, 32'd1);
        check("hold_steps", 32'(step_count), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        button = 1'b1; cyc();
        button = 1'b0; repeat (2) cyc();
        button = 1'b1; repeat (2) cyc();
        button = 1'b0; cyc();
        button = 1'b1; repeat (12) cyc();
        check("bounce_rel_pulses", pulses, 32'd1);
        check("bounce_rel_busy", 32'(busy), 32'd0);
        press_release(20, 10);
        check("second_pulses", pulses, 32'd2);
        check("second_steps", 32'(step_count), 32'd2);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) press_release(12, 10);
        check("preload_steps", 32'(step_count), 32'd255);
        press_release(12, 10);
        check("wrap_steps", 32'(step_count), 32'd0);

        // ena dropped mid-pulse truncates manual and keeps step_count
        button = 1'b0;
        repeat (7) cyc();
        check("ena_pre_manual", 32'(manual), 32'd1);
        check("ena_pre_steps", 32'(step_count), 32'd1);
        ena = 1'b0;
        cyc();
        check("ena_drop_manual", 32'(manual), 32'd0);
        check("ena_drop_busy", 32'(busy), 32'd0);
        check("ena_drop_steps", 32'(step_count), 32'd1);
        repeat (10) cyc();
        check("ena_win_busy", 32'(busy), 32'd0);
        check("ena_win_manual", 32'(manual), 32'd0);
        button = 1'b1;
        repeat (4) cyc();
        ena = 1'b1;
        repeat (3) cyc();
        check("ena_back_busy", 32'(busy), 32'd0);
        check("ena_back_steps", 32'(step_count), 32'd1);

        // Asynchronous reset mid-pulse, then a still-pressed button is a new press
        button = 1'b0;
        repeat (8) cyc();
        check("arst_pre_manual", 32'(manual), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_manual", 32'(manual), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_steps", 32'(step_count), 32'd0);
        @(negedge in_clock);
        reset_n = 1'b1;
        prev_manual = manual;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 6 || k == 7 || k == 10)
                check($sformatf("arst_repress_e%0d", k), 32'(manual), 32'((k == 7) ? 1 : 0));
        end
        check("arst_repress_steps", 32'(step_count), 32'd1);
        button = 1'b1;
        repeat (10) cyc();
        check("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/manual_step_gen.md
MANUAL_STEP_GEN -- requirements
Module: manual_step_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable samples needed to accept a press or release (10 ms at 50 MHz); legal range is 2 or more.
REQ-002 Parameter PULSE_CYCLES, default 2500000, is the high time of one manual step pulse in in_clock cycles; legal range is 1 or more.
REQ-003 in_clock  input  1  50 MHz board clock; the only clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 button  input  1  raw push-button, active-low (0 = pressed), asynchronous to in_clock and bouncing.
REQ-006 ena  input  1  step enable, 1 when the processor is in processor mode with manual clock selected.
REQ-007 manual  output  1  clean single-step clock that drives the manual input of the clock selector.
REQ-008 step_count  output  8  number of accepted steps, for the display.
REQ-009 busy  output  1  1 in every state except IDLE.

Function
REQ-010 The block SHALL register button through exactly two flops and SHALL derive an internal pressed signal, btn_s, as the inverted second flop; no other logic SHALL use button.
REQ-011 The FSM SHALL have exactly five states: IDLE, PRESS, HIGH, HOLD and RELEASE, with a single counter cnt of $clog2(max(DEBOUNCE_CYCLES, PULSE_CYCLES)) bits.
REQ-012 IDLE: if btn_s is 1, go to PRESS with cnt = 0; otherwise stay.
REQ-013 PRESS: if btn_s is 0, go to IDLE (bounce rejected); else if cnt == DEBOUNCE_CYCLES-1, go to HIGH with cnt = 0; else increment cnt.
REQ-014 HIGH: if cnt == PULSE_CYCLES-1, go to HOLD; else increment cnt; btn_s is ignored in HIGH.
REQ-015 HOLD: if btn_s is 0, go to RELEASE with cnt = 0; otherwise stay, for any hold length.
REQ-016 RELEASE: if btn_s is 1, go to HOLD; else if cnt == DEBOUNCE_CYCLES-1, go to IDLE; else increment cnt.
REQ-017 manual SHALL be 1 exactly while the state is HIGH, decoded from the state register only (glitch-free, no combinational path from button).
REQ-018 step_count SHALL increment by 1 on each transition into HIGH and SHALL wrap from 255 to 0.
REQ-019 Latency: with a clean press, manual SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge after button falls and SHALL stay high for exactly PULSE_CYCLES cycles.
REQ-020 Each accepted press SHALL produce exactly one pulse; holding the button SHALL produce no further pulses until a debounced release is followed by a new debounced press.
REQ-021 ena == 0 SHALL force the next state to IDLE with cnt = 0, including mid-pulse, which truncates manual; step_count SHALL hold its value.
REQ-022 When ena == 0 and btn_s == 1 in the same cycle, ena SHALL win.

Reset
REQ-023 While reset_n is 0: state = IDLE, cnt = 0, both synchronizer flops = 1 (released), manual = 0, busy = 0, step_count = 0.
REQ-024 Reset asserted mid-operation SHALL abort immediately, including a pulse in progress; after release, a still-pressed button SHALL be treated as a new press.

Structure
REQ-025 The state encoding (3-bit localparams IDLE=0, PRESS=1, HIGH=2, HOLD=3, RELEASE=4) SHALL live in a shared include file of processor constants, alongside the clock-select codes.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, reusable for the other board switches.

Verification (DEBOUNCE_CYCLES = 4, PULSE_CYCLES = 3)
REQ-027 Clean press held for 20 cycles -> manual high on edges 7, 8 and 9 after the press, then low; step_count goes 0 -> 1; busy stays 1 until 4 stable released samples.
REQ-028 Bounce: press 2 cycles, release 1, press 2, then release -> manual stays 0 and step_count is unchanged.
REQ-029 Hold the button for 1000 cycles with bounce on release -> exactly one pulse; a second clean press gives a second pulse and step_count = 2.
REQ-030 Preload 255 steps, then one press -> step_count = 0.
REQ-031 Drop ena during HIGH -> manual is 0 the next cycle and the state is IDLE; step_count is kept. Assert reset_n during HIGH -> all outputs 0 asynchronously, before the next clock edge.
